// File: rtl/hex_scan4.sv
// hex_scan4: time-multiplexed scan driver for a bank of common-select 7-segment digits.
// Cycles through DIGITS nibbles of a shadowed value, one SCAN_DIV-cycle slot per digit,
// with BLANK_CYCLES of all-off at the start of each slot. New values are held pending and
// only swapped into the displayed register at a frame boundary.
// Optional feature macro: HEX_SCAN_LZ_BLANK_EN (leading-zero suppression).
module hex_scan4 #(
  parameter int DIGITS       = 4,
  parameter int SCAN_DIV     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load,
  input  logic [4*DIGITS-1:0] value,
  output logic [3:0]          digit,
  output logic [DIGITS-1:0]   an,
  output logic                blank,
  output logic                frame_start
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(DIGITS);
  localparam int VW = 4 * DIGITS;

  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [VW-1:0] act_q, act_d;
  logic [VW-1:0] pend_q, pend_d;
  logic          pflag_q, pflag_d;
  // Low for one cycle after reset so the first post-reset cycle presents cnt=0, idx=0.
  logic          run_q, run_d;
  logic          slot_wrap, frame_end;

  logic [3:0]        digit_d;
  logic [DIGITS-1:0] an_d;
  logic              blank_d;
  logic              frame_start_d;

  // Next-state: slot counter, digit index, shadow register transfer and pending capture.
  always_comb begin
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    act_d     = act_q;
    pend_d    = pend_q;
    pflag_d   = pflag_q;
    run_d     = 1'b1;
    slot_wrap = run_q && (cnt_q == CW'(SCAN_DIV - 1));
    frame_end = slot_wrap && (idx_q == IW'(DIGITS - 1));
    if (run_q) begin
      if (slot_wrap) begin
        cnt_d = '0;
        idx_d = frame_end ? '0 : idx_q + IW'(1);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    // Boundary transfer uses the pending contents from before this edge.
    if (frame_end && pflag_q) begin
      act_d   = pend_q;
      pflag_d = 1'b0;
    end
    if (load) begin
      pend_d  = value;
      pflag_d = 1'b1;
    end
  end

  // Output next-state, derived from the next state so outputs line up with the state regs.
  always_comb begin
`ifdef HEX_SCAN_LZ_BLANK_EN
    int msd;
`endif
    digit_d       = act_d[{idx_d, 2'b00} +: 4];
    an_d          = '0;
    frame_start_d = (cnt_d == '0) && (idx_d == '0);
    if (int'(cnt_d) >= BLANK_CYCLES) begin
      an_d[idx_d] = 1'b1;
    end
`ifdef HEX_SCAN_LZ_BLANK_EN
    // Highest nonzero digit; digit 0 always counts as significant.
    msd = 0;
    for (int k = 1; k < DIGITS; k++) begin
      if (act_d[4*k +: 4] != 4'h0) msd = k;
    end
    if (int'(idx_d) > msd) begin
      an_d = '0;
    end
`endif
    blank_d = (an_d == '0);
  end

  // State and registered outputs; synchronous reset dominates load.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      idx_q       <= '0;
      act_q       <= '0;
      pend_q      <= '0;
      pflag_q     <= 1'b0;
      run_q       <= 1'b0;
      digit       <= 4'h0;
      an          <= '0;
      blank       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      pflag_q     <= pflag_d;
      run_q       <= run_d;
      digit       <= digit_d;
      an          <= an_d;
      blank       <= blank_d;
      frame_start <= frame_start_d;
    end
  end

endmodule
